snap_phase_capture: RTL
=======================

Name: snap_phase_capture

Overview:
- Capture engine feeding the chan_550 phase snapshot.
- Selects one channel's phase stream from the channelizer output and packs two 16-bit phase samples per 32-bit word.
- Writes the words into the snapshot BRAM and drives the 32-bit status/address word read by software through the snapPhase_addr register (its user_data_in).
- Software arms through a register bit. The capture starts on a trigger and stops when the BRAM is full.

Parameters:
ADDR_W, 10, BRAM word-address width; capacity 2^ADDR_W words
CH_W, 9, channel index width
PH_W, 16, phase sample width; packed two per 32-bit word (2*PH_W must equal 32)

Ports:
user_clk  in  1  sole clock (design fabric clock)
user_rst_n  in  1  asynchronous active-low reset
phase_in  in  PH_W  phase sample, two's complement
phase_valid  in  1  phase_in/ch_in valid this cycle
ch_in  in  CH_W  channel index of phase_in
ch_sel  in  CH_W  channel to capture (software register, quasi-static)
arm  in  1  software arm bit; rising edge is the command
trig  in  1  capture trigger, level, sampled each cycle
bram_we  out  1  BRAM write strobe
bram_addr  out  ADDR_W  BRAM word address
bram_din  out  32  packed word
addr_out  out  32  status/address word to snapPhase_addr user_data_in

Behaviour:
- Reset (user_rst_n low, async), all outputs 0:
  - state IDLE, word pointer 0, half flag 0, hold register 0, arm edge register 0.
- Arm edge: arm_r registered each cycle; arm_edge = arm & ~arm_r.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: arm_edge -> ARMED.
  - ARMED: trig=1 -> CAPTURE. A sample accepted in the trig cycle is captured (the accept rule applies in the transition cycle).
  - CAPTURE: accept = phase_valid & (ch_in == ch_sel).
    - On accept with half=0: hold <= phase_in, half <= 1.
    - On accept with half=1: next cycle bram_we=1, bram_din={phase_in, hold} (first sample in [15:0], second in [31:16]), bram_addr=pointer. Pointer then increments; half <= 0.
    - After the write to address 2^ADDR_W-1: -> DONE. The pointer saturates at 2^ADDR_W and does not wrap.
  - DONE: holds until the next arm_edge -> ARMED.
- arm_edge in any state, including CAPTURE:
  - -> ARMED; pointer, half and hold cleared.
  - Takes priority over any simultaneous accept: that sample is dropped and no bram_we is issued the next cycle.
- Write latency: exactly 1 cycle from the second accepted sample to bram_we. bram_we is high for exactly one cycle per word.
- A trailing odd sample at the end of capture is never written; capture always ends exactly at full.
- trig is ignored outside ARMED. phase_valid is ignored outside ARMED/CAPTURE.
- addr_out is registered, 1-cycle latency from the state/pointer update:
  - [31] done (state==DONE)
  - [30] capturing (state==CAPTURE)
  - [29] armed (state==ARMED)
  - [28:ADDR_W+1] zero
  - [ADDR_W:0] words written since the last arm (0..2^ADDR_W)
- Reset mid-capture: immediate return to IDLE, bram_we forced low asynchronously, count 0.

Test Plan:
- Reset, then arm 0->1, ch_sel=5, trig pulse, then valid samples on ch 5 with phase 0x0001,0x0002 -> one bram_we, addr 0, din 0x00020001; addr_out=0x40000001.
- Interleave ch 4 and ch 5 samples with ch_sel=5 -> only ch 5 samples packed; ch 4 never appears in bram_din.
- Stream 2048 matching samples with ADDR_W=10 -> last write at addr 1023, addr_out=0x80000400; further samples produce no bram_we.
- Arm edge in the same cycle as the second sample of a pair mid-capture (count=7) -> no write the next cycle; addr_out=0x20000000; awaits trig again.
- Arm held at 1 continuously after the first edge -> no re-arm; trig while in DONE ignored; a new 0->1 on arm re-arms.
- Assert user_rst_n low during CAPTURE, with a write pending -> bram_we 0 immediately, addr_out 0, state IDLE after release.

Source files
------------

// File: rtl/snap_phase_capture.sv
// Phase snapshot capture: selects one channel's phase stream, packs two
// samples per word into the snapshot BRAM and reports status/count.
//
// Ports:
//   user_clk, user_rst_n : clock, async active-low reset
//   phase_in, phase_valid, ch_in : channelizer phase stream
//   ch_sel   : channel to capture
//   arm      : software arm bit (rising edge re-arms)
//   trig     : capture trigger, honoured only while armed
//   bram_we, bram_addr, bram_din : snapshot BRAM write port
//   addr_out : {done, capturing, armed, 0..., word count}
module snap_phase_capture #(
    parameter int ADDR_W = 10,
    parameter int CH_W   = 9,
    parameter int PH_W   = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [PH_W-1:0]   phase_in,
    input  logic              phase_valid,
    input  logic [CH_W-1:0]   ch_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              arm,
    input  logic              trig,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic [31:0]       addr_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic                half_q, half_d;
    logic [PH_W-1:0]     hold_q, hold_d;
    logic                arm_r_q, arm_r_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic [31:0]         stat_q, stat_d;

    logic arm_edge;
    logic sel;
    logic accept;

    always_comb begin
        arm_edge = arm & ~arm_r_q;
        sel      = phase_valid & (ch_in == ch_sel);
        // Trig cycle counts as capturing; a re-arm drops the sample.
        accept   = sel & ~arm_edge &
                   ((state_q == S_CAP) |
                    ((state_q == S_ARMED) & trig));

        state_d = state_q;
        ptr_d   = ptr_q;
        half_d  = half_q;
        hold_d  = hold_q;
        arm_r_d = arm;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        if (arm_edge) begin
            state_d = S_ARMED;
            ptr_d   = '0;
            half_d  = 1'b0;
            hold_d  = '0;
        end else begin
            if ((state_q == S_ARMED) && trig) begin
                state_d = S_CAP;
            end
            if (accept) begin
                if (!half_q) begin
                    hold_d = phase_in;
                    half_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    din_d  = {phase_in, hold_q};
                    addr_d = ptr_q[ADDR_W-1:0];
                    ptr_d  = ptr_q + (ADDR_W+1)'(1);
                    half_d = 1'b0;
                    // Last slot: stop, count saturates at full.
                    if (ptr_q[ADDR_W-1:0] == '1) begin
                        state_d = S_DONE;
                    end
                end
            end
        end
    end

    always_comb begin
        stat_d           = '0;
        stat_d[31]       = (state_q == S_DONE);
        stat_d[30]       = (state_q == S_CAP);
        stat_d[29]       = (state_q == S_ARMED);
        stat_d[ADDR_W:0] = ptr_q;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            half_q  <= 1'b0;
            hold_q  <= '0;
            arm_r_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            half_q  <= half_d;
            hold_q  <= hold_d;
            arm_r_q <= arm_r_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            stat_q  <= stat_d;
        end
    end

    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign addr_out  = stat_q;

endmodule
